// File: rtl/transparency_pkg.sv
// Shared transparency definitions: default precision, proportion "one" value and fade states.
package transparency_pkg;

    localparam int unsigned TRANSPARENCY_PRECISION = 4;
    localparam int unsigned PROPORTION_ONE         = 1 << TRANSPARENCY_PRECISION;

    typedef enum logic {
        StIdle,
        StRamp
    } fade_state_e;

    function automatic int unsigned proportion_one(input int unsigned precision);
        return 1 << precision;
    endfunction

endpackage

// File: rtl/frame_step_divider.sv
// Counts qualified frame_start pulses and fires step_tick on every div-th one.
module frame_step_divider #(
    parameter int unsigned FRAME_DIV_WIDTH = 8
) (
    input  logic                       i_clk,
    input  logic                       i_rst_n,
    input  logic                       i_frame_start,
    input  logic                       i_clear,
    input  logic [FRAME_DIV_WIDTH-1:0] i_div,
    output logic                       o_step_tick
);

    logic [FRAME_DIV_WIDTH-1:0] r_count;
    logic [FRAME_DIV_WIDTH-1:0] w_count_d;
    logic                       w_tick;

    always_comb begin
        w_count_d = r_count;
        w_tick    = 1'b0;
        // clear wins so a frame_start coinciding with start is not counted
        if (i_clear) begin
            w_count_d = '0;
        end else if (i_frame_start) begin
            if (r_count >= i_div - FRAME_DIV_WIDTH'(1)) begin
                w_tick    = 1'b1;
                w_count_d = '0;
            end else begin
                w_count_d = r_count + FRAME_DIV_WIDTH'(1);
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_count <= '0;
        end else begin
            r_count <= w_count_d;
        end
    end

    assign o_step_tick = w_tick;

endmodule

// File: rtl/transparency_fade_controller.sv
// Frame-synchronous fade of src_a_proportion toward a programmed target.
// Optional ping-pong looping via macro TRANSPARENCY_FADE_LOOP_EN (adds i_loop_mode).
module transparency_fade_controller #(
    parameter int unsigned TRANSPARENCY_PRECISION = transparency_pkg::TRANSPARENCY_PRECISION,
    parameter int unsigned FRAME_DIV_WIDTH        = 8
) (
    input  logic                              i_clk,
    input  logic                              i_rst_n,
    input  logic                              i_frame_start,
    input  logic                              i_start,
    input  logic [TRANSPARENCY_PRECISION:0]   i_target_proportion,
    input  logic [TRANSPARENCY_PRECISION:0]   i_step,
    input  logic [FRAME_DIV_WIDTH-1:0]        i_frames_per_step,
`ifdef TRANSPARENCY_FADE_LOOP_EN
    input  logic                              i_loop_mode,
`endif
    output logic [TRANSPARENCY_PRECISION:0]   o_src_a_proportion,
    output logic                              o_busy,
    output logic                              o_done
);

    import transparency_pkg::*;

    localparam int unsigned W   = TRANSPARENCY_PRECISION + 1;
    localparam int unsigned FDW = FRAME_DIV_WIDTH;
    localparam logic [W-1:0] ONE = W'(proportion_one(TRANSPARENCY_PRECISION));

    fade_state_e    r_state, w_state_d;
    logic [W-1:0]   r_prop, r_target, r_step, r_origin;
    logic [W-1:0]   w_prop_d, w_target_d, w_step_d, w_origin_d;
    logic [FDW-1:0] r_div, w_div_d;
    logic           r_busy, r_done, w_done_d;

    logic [W-1:0]   w_target_in;
    logic [FDW-1:0] w_div_in;
    logic [W:0]     w_sum, w_diff;
    logic [W-1:0]   w_stepped;
    logic           w_step_tick;
    logic           w_loop;

`ifdef TRANSPARENCY_FADE_LOOP_EN
    assign w_loop = i_loop_mode;
`else
    assign w_loop = 1'b0;
`endif

    frame_step_divider #(
        .FRAME_DIV_WIDTH(FDW)
    ) u_divider (
        .i_clk        (i_clk),
        .i_rst_n      (i_rst_n),
        .i_frame_start(i_frame_start && (r_state == StRamp)),
        .i_clear      (i_start),
        .i_div        (r_div),
        .o_step_tick  (w_step_tick)
    );

    always_comb begin
        w_target_in = (i_target_proportion > ONE) ? ONE : i_target_proportion;
        w_div_in    = (i_frames_per_step == '0) ? FDW'(1) : i_frames_per_step;
        w_sum       = {1'b0, r_prop} + {1'b0, r_step};
        w_diff      = {1'b0, r_prop} - {1'b0, r_step};
        // W+1-bit intermediates catch overflow/underflow before clamping to target
        if (r_step == '0) begin
            w_stepped = r_target;
        end else if (r_prop < r_target) begin
            w_stepped = (w_sum >= {1'b0, r_target}) ? r_target : w_sum[W-1:0];
        end else begin
            w_stepped = (w_diff[W] || (w_diff[W-1:0] <= r_target)) ? r_target : w_diff[W-1:0];
        end
    end

    always_comb begin
        w_state_d  = r_state;
        w_prop_d   = r_prop;
        w_target_d = r_target;
        w_step_d   = r_step;
        w_origin_d = r_origin;
        w_div_d    = r_div;
        w_done_d   = 1'b0;
        if (i_start) begin
            w_target_d = w_target_in;
            w_step_d   = i_step;
            w_div_d    = w_div_in;
            w_origin_d = r_prop;
            if (w_target_in == r_prop) begin
                w_state_d = StIdle;
                w_done_d  = 1'b1;
            end else begin
                w_state_d = StRamp;
            end
        end else if ((r_state == StRamp) && w_step_tick) begin
            w_prop_d = w_stepped;
            if (w_stepped == r_target) begin
                w_done_d = 1'b1;
                if (w_loop) begin
                    w_target_d = r_origin;
                    w_origin_d = r_target;
                end else begin
                    w_state_d = StIdle;
                end
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state  <= StIdle;
            r_prop   <= ONE;
            r_target <= '0;
            r_step   <= '0;
            r_origin <= '0;
            r_div    <= '0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
        end else begin
            r_state  <= w_state_d;
            r_prop   <= w_prop_d;
            r_target <= w_target_d;
            r_step   <= w_step_d;
            r_origin <= w_origin_d;
            r_div    <= w_div_d;
            r_busy   <= (w_state_d == StRamp);
            r_done   <= w_done_d;
        end
    end

    assign o_src_a_proportion = r_prop;
    assign o_busy             = r_busy;
    assign o_done             = r_done;

endmodule

// File: tb/tb_transparency_fade_controller.sv
// Directed scoreboard bench for transparency_fade_controller (P = 4, FDW = 8).
module tb_transparency_fade_controller;

    typedef struct packed {
        logic [4:0] prop;
        logic       busy;
        logic       done;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       frame_start;
    logic       start;
    logic [4:0] target_proportion;
    logic [4:0] step;
    logic [7:0] frames_per_step;
    logic [4:0] src_a_proportion;
    logic       busy;
    logic       done;

    exp_t exp_q[$];
    int   vectors     = 0;
    int   miscompares = 0;

    always #5 clk = ~clk;

    transparency_fade_controller #(
        .TRANSPARENCY_PRECISION(4),
        .FRAME_DIV_WIDTH       (8)
    ) dut (
        .i_clk              (clk),
        .i_rst_n            (rst_n),
        .i_frame_start      (frame_start),
        .i_start            (start),
        .i_target_proportion(target_proportion),
        .i_step             (step),
        .i_frames_per_step  (frames_per_step),
`ifdef TRANSPARENCY_FADE_LOOP_EN
        .i_loop_mode        (1'b0),
`endif
        .o_src_a_proportion (src_a_proportion),
        .o_busy             (busy),
        .o_done             (done)
    );

    task automatic check_out(input string tag);
        exp_t e;
        if (exp_q.size() == 0) begin
            vectors++;
            miscompares++;
            $error("FAIL %s scoreboard empty", tag);
            return;
        end
        e = exp_q.pop_front();
        vectors++;
        assert (src_a_proportion === e.prop) else begin
            miscompares++;
            $error("FAIL %s.prop got %0d want %0d", tag, src_a_proportion, e.prop);
        end
        vectors++;
        assert (busy === e.busy) else begin
            miscompares++;
            $error("FAIL %s.busy got %0b want %0b", tag, busy, e.busy);
        end
        vectors++;
        assert (done === e.done) else begin
            miscompares++;
            $error("FAIL %s.done got %0b want %0b", tag, done, e.done);
        end
    endtask

    // Drive one cycle of strobes (called just after a negedge) and check at the next negedge
    task automatic cycle(input logic fs, input logic st, input logic [4:0] p, input logic b,
                         input logic d, input string tag);
        exp_q.push_back('{prop: p, busy: b, done: d});
        frame_start = fs;
        start       = st;
        @(posedge clk);
        @(negedge clk);
        frame_start = 1'b0;
        start       = 1'b0;
        check_out(tag);
    endtask

    task automatic start_fade(input logic [4:0] tgt, input logic [4:0] stp, input logic [7:0] div,
                              input logic fs, input logic [4:0] p, input logic b, input logic d,
                              input string tag);
        target_proportion = tgt;
        step              = stp;
        frames_per_step   = div;
        cycle(fs, 1'b1, p, b, d, tag);
    endtask

    initial begin
        rst_n             = 1'b0;
        frame_start       = 1'b0;
        start             = 1'b0;
        target_proportion = '0;
        step              = '0;
        frames_per_step   = '0;
        @(negedge clk);
        exp_q.push_back('{prop: 5'd16, busy: 1'b0, done: 1'b0});
        check_out("reset");
        rst_n = 1'b1;
        @(negedge clk);

        // frame_start in idle does nothing
        cycle(1'b1, 1'b0, 5'd16, 1'b0, 1'b0, "idle_frame0");

        // down 16 -> 0 by 4, div 1
        start_fade(5'd0, 5'd4, 8'd1, 1'b0, 5'd16, 1'b1, 1'b0, "t2_start");
        cycle(1'b1, 1'b0, 5'd12, 1'b1, 1'b0, "t2_f1");
        cycle(1'b1, 1'b0, 5'd8,  1'b1, 1'b0, "t2_f2");
        cycle(1'b1, 1'b0, 5'd4,  1'b1, 1'b0, "t2_f3");
        cycle(1'b1, 1'b0, 5'd0,  1'b0, 1'b1, "t2_f4");
        cycle(1'b0, 1'b0, 5'd0,  1'b0, 1'b0, "t2_after");

        // up 0 -> 16 by 5, saturating
        start_fade(5'd16, 5'd5, 8'd1, 1'b0, 5'd0, 1'b1, 1'b0, "t3_start");
        cycle(1'b1, 1'b0, 5'd5,  1'b1, 1'b0, "t3_f1");
        cycle(1'b1, 1'b0, 5'd10, 1'b1, 1'b0, "t3_f2");
        cycle(1'b1, 1'b0, 5'd15, 1'b1, 1'b0, "t3_f3");
        cycle(1'b1, 1'b0, 5'd16, 1'b0, 1'b1, "t3_f4");
        cycle(1'b1, 1'b0, 5'd16, 1'b0, 1'b0, "t3_after");

        // div 3, step 8: changes on 3rd and 6th frame only
        start_fade(5'd0, 5'd8, 8'd3, 1'b0, 5'd16, 1'b1, 1'b0, "t4_start");
        cycle(1'b1, 1'b0, 5'd16, 1'b1, 1'b0, "t4_f1");
        cycle(1'b1, 1'b0, 5'd16, 1'b1, 1'b0, "t4_f2");
        cycle(1'b0, 1'b0, 5'd16, 1'b1, 1'b0, "t4_gap");
        cycle(1'b1, 1'b0, 5'd8,  1'b1, 1'b0, "t4_f3");
        cycle(1'b1, 1'b0, 5'd8,  1'b1, 1'b0, "t4_f4");
        cycle(1'b1, 1'b0, 5'd8,  1'b1, 1'b0, "t4_f5");
        cycle(1'b1, 1'b0, 5'd0,  1'b0, 1'b1, "t4_f6");

        // step 0 jumps straight to target
        start_fade(5'd16, 5'd0, 8'd1, 1'b0, 5'd0, 1'b1, 1'b0, "jump_start");
        cycle(1'b1, 1'b0, 5'd16, 1'b0, 1'b1, "jump_f1");

        // retarget mid-ramp: heading to 0, at 8 restart toward 4
        start_fade(5'd0, 5'd4, 8'd1, 1'b0, 5'd16, 1'b1, 1'b0, "t5_start");
        cycle(1'b1, 1'b0, 5'd12, 1'b1, 1'b0, "t5_f1");
        cycle(1'b1, 1'b0, 5'd8,  1'b1, 1'b0, "t5_f2");
        start_fade(5'd4, 5'd4, 8'd1, 1'b0, 5'd8, 1'b1, 1'b0, "t5_restart");
        cycle(1'b1, 1'b0, 5'd4, 1'b0, 1'b1, "t5_f3");

        // target above ONE clamps to 16; div 0 behaves as 1
        start_fade(5'd31, 5'd6, 8'd0, 1'b0, 5'd4, 1'b1, 1'b0, "clamp_start");
        cycle(1'b1, 1'b0, 5'd10, 1'b1, 1'b0, "clamp_f1");
        cycle(1'b1, 1'b0, 5'd16, 1'b0, 1'b1, "clamp_f2");

        // start with target equal to current: no ramp, done next cycle
        start_fade(5'd16, 5'd3, 8'd1, 1'b0, 5'd16, 1'b0, 1'b1, "equal_start");
        cycle(1'b1, 1'b0, 5'd16, 1'b0, 1'b0, "equal_after");

        // start and frame_start together: that frame is not counted (div 2)
        start_fade(5'd0, 5'd8, 8'd2, 1'b1, 5'd16, 1'b1, 1'b0, "t6_start");
        cycle(1'b1, 1'b0, 5'd16, 1'b1, 1'b0, "t6_f1");
        cycle(1'b1, 1'b0, 5'd8,  1'b1, 1'b0, "t6_f2");
        cycle(1'b1, 1'b0, 5'd8,  1'b1, 1'b0, "t6_f3");

        // asynchronous reset mid-fade
        exp_q.push_back('{prop: 5'd16, busy: 1'b0, done: 1'b0});
        rst_n = 1'b0;
        #1;
        check_out("t6_async_rst");
        @(negedge clk);
        rst_n = 1'b1;
        cycle(1'b1, 1'b0, 5'd16, 1'b0, 1'b0, "t6_post_rst");

        vectors++;
        assert (exp_q.size() == 0) else begin
            miscompares++;
            $error("FAIL scoreboard_drain got %0d left want 0", exp_q.size());
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
